// File: rtl/dequant_lane_serializer.sv
// Buffers 8-lane fp32 vectors from linear_dequant and replays them one lane per cycle.
// Latency: a vector written at edge N shows lane 0 on the output in cycle N+1 (no bypass).
// Backpressure: out_ready stalls the lane stream; vectors that arrive while full are dropped and flagged.
module dequant_lane_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [22:0]              in_man_0,
    input  logic [22:0]              in_man_1,
    input  logic [22:0]              in_man_2,
    input  logic [22:0]              in_man_3,
    input  logic [22:0]              in_man_4,
    input  logic [22:0]              in_man_5,
    input  logic [22:0]              in_man_6,
    input  logic [22:0]              in_man_7,
    input  logic [7:0]               in_exp_0,
    input  logic [7:0]               in_exp_1,
    input  logic [7:0]               in_exp_2,
    input  logic [7:0]               in_exp_3,
    input  logic [7:0]               in_exp_4,
    input  logic [7:0]               in_exp_5,
    input  logic [7:0]               in_exp_6,
    input  logic [7:0]               in_exp_7,
    input  logic                     in_sign_0,
    input  logic                     in_sign_1,
    input  logic                     in_sign_2,
    input  logic                     in_sign_3,
    input  logic                     in_sign_4,
    input  logic                     in_sign_5,
    input  logic                     in_sign_6,
    input  logic                     in_sign_7,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [22:0]              out_man,
    output logic [7:0]               out_exp,
    output logic                     out_sign,
    output logic [2:0]               out_lane,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } lane_t;

    typedef lane_t [7:0] vec_t;

    vec_t            mem_q [DEPTH];
    vec_t            in_vec;
    lane_t           head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [2:0]      lane_idx_q, lane_idx_d;
    logic            overflow_q, overflow_d;
    logic            full, beat, pop_vec, wr, drop;

    always_comb begin
        in_vec[0] = {in_sign_0, in_exp_0, in_man_0};
        in_vec[1] = {in_sign_1, in_exp_1, in_man_1};
        in_vec[2] = {in_sign_2, in_exp_2, in_man_2};
        in_vec[3] = {in_sign_3, in_exp_3, in_man_3};
        in_vec[4] = {in_sign_4, in_exp_4, in_man_4};
        in_vec[5] = {in_sign_5, in_exp_5, in_man_5};
        in_vec[6] = {in_sign_6, in_exp_6, in_man_6};
        in_vec[7] = {in_sign_7, in_exp_7, in_man_7};
    end

    // out_valid depends only on registered count, never on out_ready
    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign beat      = out_valid & out_ready;
    assign pop_vec   = beat & (lane_idx_q == 3'd7);
    assign wr        = in_valid & enable & (~full | pop_vec);
    assign drop      = in_valid & enable & full & ~pop_vec;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lane_idx_d = lane_idx_q;
        overflow_d = overflow_q;
        if (beat) begin
            lane_idx_d = lane_idx_q + 3'd1;
        end
        if (pop_vec) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (wr && !pop_vec) begin
            count_d = count_q + 1'b1;
        end else if (pop_vec && !wr) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_idx_q <= lane_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Vector storage carries no reset; count gates every read
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= in_vec;
        end
    end

    assign head       = mem_q[rd_ptr_q][lane_idx_q];
    assign out_man    = out_valid ? head.man  : '0;
    assign out_exp    = out_valid ? head.exp  : '0;
    assign out_sign   = out_valid ? head.sign : 1'b0;
    assign out_lane   = out_valid ? lane_idx_q : '0;
    assign out_last   = out_valid & (lane_idx_q == 3'd7);
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dequant_lane_serializer.sv
// Bench for dequant_lane_serializer: directed scenarios plus random traffic,
// all compared against a queue-of-vectors reference model.
module tb_dequant_lane_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [22:0] t_man [8];
    logic [7:0]  t_exp [8];
    logic        t_sign [8];

    logic        out_valid;
    logic [22:0] out_man;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic [2:0]  out_lane;
    logic        out_last;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dequant_lane_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
        .in_man_0(t_man[0]), .in_man_1(t_man[1]), .in_man_2(t_man[2]), .in_man_3(t_man[3]),
        .in_man_4(t_man[4]), .in_man_5(t_man[5]), .in_man_6(t_man[6]), .in_man_7(t_man[7]),
        .in_exp_0(t_exp[0]), .in_exp_1(t_exp[1]), .in_exp_2(t_exp[2]), .in_exp_3(t_exp[3]),
        .in_exp_4(t_exp[4]), .in_exp_5(t_exp[5]), .in_exp_6(t_exp[6]), .in_exp_7(t_exp[7]),
        .in_sign_0(t_sign[0]), .in_sign_1(t_sign[1]), .in_sign_2(t_sign[2]), .in_sign_3(t_sign[3]),
        .in_sign_4(t_sign[4]), .in_sign_5(t_sign[5]), .in_sign_6(t_sign[6]), .in_sign_7(t_sign[7]),
        .out_ready(out_ready), .out_valid(out_valid), .out_man(out_man), .out_exp(out_exp),
        .out_sign(out_sign), .out_lane(out_lane), .out_last(out_last),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    // Reference model: a queue of whole vectors, head lane position, sticky drop flag
    logic [255:0] mq [$];
    int           m_lane = 0;
    bit           m_ovf  = 1'b0;

    function automatic logic [255:0] cur_vec();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = {t_sign[k], t_exp[k], t_man[k]};
        return v;
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            mq.delete();
            m_lane = 0;
            m_ovf  = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) begin
                if (m_lane == 7) begin
                    void'(mq.pop_front());
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
            if (in_valid && enable) begin
                if (mq.size() < DEPTH) mq.push_back(cur_vec());
                else m_ovf = 1'b1;
            end
        end
    end

    function automatic logic [40:0] model_bus();
        logic [31:0] ln;
        if (mq.size() == 0) return {37'd0, 3'd0, m_ovf};
        ln = mq[0][m_lane*32 +: 32];
        return {1'b1, 3'(m_lane), (m_lane == 7), ln, 3'(mq.size()), m_ovf};
    endfunction

    wire [40:0] act_bus = {out_valid, out_lane, out_last, out_sign, out_exp, out_man, fifo_level, overflow};

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < 8; k++) begin
            t_man[k]  = 23'($urandom);
            t_exp[k]  = 8'($urandom);
            t_sign[k] = 1'($urandom);
        end
    endtask

    task automatic tag_lanes(input int id);
        rand_lanes();
        for (int k = 0; k < 8; k++) t_man[k] = 23'(id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
        rand_lanes();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (act_bus !== 41'd0) begin
                n_fail++;
                $display("FAIL reset_hold: outputs %h, required all zero", act_bus);
            end
            rand_lanes();
            cyc();
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || act_bus !== model_bus()) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b level=%0d bus=%h, required valid=0 level=0 bus=%h",
                     out_valid, fifo_level, act_bus, model_bus());
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 8; k++) begin
            t_sign[k] = 1'(k & 1);
            t_exp[k]  = 8'(8'h80 + k);
            t_man[k]  = 23'(k + 1);
        end
        in_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_prewrite: out_valid=%b, required 0", out_valid);
        end
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({out_valid, out_lane, out_last, out_sign, out_exp, out_man} !==
                {1'b1, 3'(k), (k == 7), 1'(k & 1), 8'(8'h80 + k), 23'(k + 1)} ||
                act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL single_lane%0d: v=%b lane=%0d last=%b s=%b e=%h m=%h, required v=1 lane=%0d last=%b s=%b e=%h m=%h",
                         k, out_valid, out_lane, out_last, out_sign, out_exp, out_man,
                         k, (k == 7), 1'(k & 1), 8'(8'h80 + k), 23'(k + 1));
            end
            cyc();
        end
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drained: valid=%b level=%0d last=%b, required 0 0 0",
                     out_valid, fifo_level, out_last);
        end
    endtask

    task automatic test_backpressure();
        int cycles = 0;
        bit prev_rdy = 1'b1;
        logic [2:0] prev_lane = '0;
        logic [22:0] prev_man = '0;
        rand_lanes();
        out_ready = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
            n_checks++;
            if (act_bus !== model_bus() ||
                (!prev_rdy && (out_lane !== prev_lane || out_man !== prev_man))) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: bus=%h, required %h (held lane %0d man %h)",
                         c, act_bus, model_bus(), prev_lane, prev_man);
            end
            prev_lane = out_lane;
            prev_man  = out_man;
            out_ready = (c % 2 == 0);
            prev_rdy  = out_ready;
            cycles++;
            cyc();
        end
        out_ready = 1'b0;
        n_checks++;
        if (cycles !== 15) begin
            n_fail++;
            $display("FAIL bp_drain_cycles: got %0d, required 15", cycles);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0; enable = 1'b1;
        for (int id = 0; id < 5; id++) begin
            tag_lanes(id);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || act_bus !== model_bus()) begin
            n_fail++;
            $display("FAIL ovf_fill: level=%0d ovf=%b, required level=4 ovf=1", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 32; b++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_man !== 23'(b / 8) || out_lane !== 3'(b % 8) ||
                act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL ovf_beat%0d: v=%b id=%0d lane=%0d, required v=1 id=%0d lane=%0d",
                         b, out_valid, out_man, out_lane, b / 8, b % 8);
            end
            cyc();
        end
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after: valid=%b ovf=%b, required valid=0 ovf=1", out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int id = 0; id < 2; id++) begin
            rand_lanes();
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) cyc();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (act_bus !== 41'd0 || act_bus !== model_bus()) begin
            n_fail++;
            $display("FAIL reset_async: outputs %h, required all zero", act_bus);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_idle%0d: valid=%b level=%0d ovf=%b, required 0 0 0",
                         i, out_valid, fifo_level, overflow);
            end
            cyc();
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int id = 10; id < 14; id++) begin
            tag_lanes(id);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (7) cyc();
        n_checks++;
        if (out_lane !== 3'd7 || fifo_level !== 3'd4 || out_last !== 1'b1 || act_bus !== model_bus()) begin
            n_fail++;
            $display("FAIL fullpop_head: lane=%0d level=%0d last=%b, required lane=7 level=4 last=1",
                     out_lane, fifo_level, out_last);
        end
        tag_lanes(14);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || act_bus !== model_bus()) begin
            n_fail++;
            $display("FAIL fullpop_write: level=%0d ovf=%b, required level=4 ovf=0", fifo_level, overflow);
        end
        for (int b = 0; b < 32; b++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_man !== 23'(11 + b / 8) || act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL fullpop_beat%0d: v=%b id=%0d, required v=1 id=%0d",
                         b, out_valid, out_man, 11 + b / 8);
            end
            cyc();
        end
    endtask

    task automatic test_enable();
        int beats = 0;
        logic [2:0] prev_level;
        out_ready = 1'b0; enable = 1'b1;
        for (int id = 0; id < 2; id++) begin
            rand_lanes();
            in_valid = 1'b1;
            cyc();
        end
        prev_level = fifo_level;
        out_ready = 1'b1; enable = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_lanes();
            if (out_valid === 1'b1) beats++;
            cyc();
            n_checks++;
            if (fifo_level > prev_level || overflow !== 1'b0 || act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL enable_off%0d: level=%0d (was %0d) ovf=%b, required no growth, ovf=0",
                         i, fifo_level, prev_level, overflow);
            end
            prev_level = fifo_level;
        end
        enable = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
            n_checks++;
            if (act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL enable_drain%0d: bus=%h, required %h", c, act_bus, model_bus());
            end
            beats++;
            cyc();
        end
        n_checks++;
        if (beats !== 16 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_total: beats=%0d valid=%b, required beats=16 valid=0", beats, out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rand_lanes();
            in_valid  = ($urandom_range(0, 2) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            n_checks++;
            if (act_bus !== model_bus()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: bus=%h, required %h", c, act_bus, model_bus());
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            t_man[k] = '0; t_exp[k] = '0; t_sign[k] = 1'b0;
        end
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_full_pop();
        test_enable();
        test_random();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dequant_lane_serializer.md
# dequant_lane_serializer

- Sits directly downstream of `linear_dequant` in the SFU datapath.
- Captures each 8-lane fp32 vector that `linear_dequant` emits on its valid strobe into a small vector FIFO.
- Replays the stored vectors one lane per cycle on a ready/valid stream for the single-lane consumer.
- Needed because `linear_dequant` has no backpressure: this block absorbs bursts and flags any vector it has to drop.

## Interface
Parameters:
- DEPTH, 4, vector entries in FIFO; power of 2, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- enable  input  1  write-side enable (same net as upstream enable). Gates capture only; read side runs regardless.
- in_valid  input  1  vector strobe from upstream dst_valid.
- in_man_0..in_man_7  input  23 each  lane mantissas.
- in_exp_0..in_exp_7  input  8 each  lane exponents.
- in_sign_0..in_sign_7  input  1 each  lane signs.
- out_ready  input  1  consumer accepts current lane.
- out_valid  output  1  lane data valid.
- out_man  output  23  current lane mantissa.
- out_exp  output  8  current lane exponent.
- out_sign  output  1  current lane sign.
- out_lane  output  3  index of current lane, 0..7.
- out_last  output  1  high when out_lane==7 and out_valid.
- fifo_level  output  $clog2(DEPTH)+1  stored vectors, including the partially drained head.
- overflow  output  1  sticky; set when a vector is dropped.

## Operation
- Storage: DEPTH entries × 256 bits (8 × {sign,exp,man}). Memory is not reset.
- State: wr_ptr, rd_ptr (wrap modulo DEPTH), count (0..DEPTH), lane_idx (0..7), overflow.
- Write (wr) = in_valid & enable & (count<DEPTH | pop_vec).
  - Writes all 8 lanes to mem[wr_ptr]; wr_ptr++.
- Drop = in_valid & enable & count==DEPTH & !pop_vec.
  - Sets overflow; vector discarded; no state changes.
- in_valid while enable=0: ignored, no overflow.
- out_valid = (count≠0).
- Output data = mem[rd_ptr] lane lane_idx when out_valid; out_man/out_exp/out_sign/out_lane all 0 otherwise.
- Beat = out_valid & out_ready.
  - lane_idx++ on each beat.
  - Beat at lane_idx==7 is pop_vec: lane_idx→0, rd_ptr++.
- count update: +1 on wr, −1 on pop_vec, unchanged when both or neither.
- Data pass-through is bit-exact: no rounding, normalisation or special-value handling.
- Lanes leave in order 0..7; vectors leave in arrival order.

## Timing
- Reset (async assert, sync-safe deassert): all pointers, count, lane_idx and overflow = 0.
  - All outputs 0 while in reset and after it: out_valid 0, out_last 0, fifo_level 0, overflow 0.
- Reset mid-operation: all stored vectors and any partially drained head are discarded; no output afterwards until a new write.
- Latency: vector written at edge N → out_valid=1, lane 0 visible, in cycle N+1.
- Throughput:
  - Read side: 1 lane/cycle, so one vector per 8 cycles with out_ready held high.
  - Write side: 1 vector/cycle.
- Handshake:
  - Once asserted, out_valid and the data stay stable until a beat occurs.
  - out_ready may toggle freely.
  - No combinational path from out_ready to out_valid.
- Full with simultaneous pop_vec and write: write accepted, count stays DEPTH, overflow unchanged.
- Empty with simultaneous write: write only; out_valid rises the next cycle, with no bypass.
- overflow clears only on reset.

## Test plan
1. Reset: rstn=0 with in_valid=1 and random lanes → every output 0; after release, fifo_level=0 and out_valid=0.
2. Single vector, lane k = {sign=k[0], exp=8'h80+k, man=k+1}, written at edge N, out_ready=1 → out_valid from cycle N+1; 8 consecutive beats lanes 0..7 with matching data; out_last on lane 7 only; fifo_level returns 0.
3. Backpressure: one vector, out_ready pattern 1,0,1,0… → lane advances only on ready cycles; data/out_lane held while ready=0; 15 cycles to drain.
4. Fill/overflow, DEPTH=4, out_ready=0, 5 back-to-back vectors tagged man=vec id → fifo_level=4, overflow=1 after the 5th, 5th dropped; then out_ready=1 yields 32 beats, vector ids 0..3 in order.
5. Full + pop: fifo_level=4, head at lane 7, out_ready=1, in_valid=1 same cycle → write accepted, fifo_level stays 4, overflow stays 0, new vector emerges last.
6. enable=0 with in_valid=1 for 3 cycles while draining → no write, no overflow, fifo_level only decrements; drain continues unaffected.
